// File: rtl/axi_rd_req_scheduler.sv
// Round-robin scheduler sharing one AXI read-channel controller
// among NUM_REQ requesters, with beat routing and a stall watchdog.
module axi_rd_req_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int addr_width = 32,
    parameter int data_width = 64,
    parameter int TIMEOUT    = 256
) (
    input  logic                       AClk,
    input  logic                       ARst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*addr_width-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]       req_len,
    input  logic [NUM_REQ*3-1:0]       req_size,
    input  logic [NUM_REQ*2-1:0]       req_burst,
    output logic [addr_width-1:0]      araddr_d,
    output logic [3:0]                 TXN_ID_R_d,
    output logic [1:0]                 arburst_d,
    output logic [3:0]                 arlen_d,
    output logic [2:0]                 arsize_d,
    output logic [1:0]                 arlock_d,
    output logic [1:0]                 arcache_d,
    output logic [2:0]                 arprot_d,
    output logic                       rd_trn_en,
    input  logic [data_width-1:0]      rdata_d,
    input  logic [1:0]                 rresp_d,
    input  logic [3:0]                 rid_d,
    input  logic                       rd_rsp_en_d,
    input  logic                       r_last_d,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [data_width-1:0]      rsp_data,
    output logic [1:0]                 rsp_resp,
    output logic                       rsp_last,
    output logic                       id_err,
    output logic                       busy
);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state;
    logic [1:0]         seq;
    logic [1:0]         last_gnt;
    logic [1:0]         gnt_idx;
    logic [3:0]         beat_cnt;
    logic [WW-1:0]      wdog;
    logic               any;
    logic [1:0]         win;
    logic [NUM_REQ-1:0] sh;
    int                 idx;
    logic               unused_ok;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] i);
        onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
    endfunction

    // First pending requester after the last grant, wrapping.
    always_comb begin
        any = 1'b0;
        win = '0;
        sh  = '0;
        idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_gnt) + k) % NUM_REQ;
            sh  = req_valid >> idx;
            if (!any && sh[0]) begin
                any = 1'b1;
                win = idx[1:0];
            end
        end
    end

    assign req_ready = (state == IDLE && any && ARst) ? onehot(win) : '0;
    assign busy      = (state != IDLE);
    assign unused_ok = r_last_d;

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            state      <= IDLE;
            seq        <= '0;
            last_gnt   <= 2'(NUM_REQ - 1);
            gnt_idx    <= '0;
            beat_cnt   <= '0;
            wdog       <= '0;
            araddr_d   <= '0;
            TXN_ID_R_d <= '0;
            arburst_d  <= '0;
            arlen_d    <= '0;
            arsize_d   <= '0;
            arlock_d   <= '0;
            arcache_d  <= '0;
            arprot_d   <= '0;
            rd_trn_en  <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_resp   <= '0;
            rsp_last   <= 1'b0;
            id_err     <= 1'b0;
        end else begin
            rd_trn_en <= 1'b0;
            rsp_valid <= '0;
            rsp_last  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        gnt_idx    <= win;
                        araddr_d   <= addr_width'(req_addr >> (int'(win) * addr_width));
                        arlen_d    <= 4'(req_len >> (int'(win) * 4));
                        arsize_d   <= 3'(req_size >> (int'(win) * 3));
                        arburst_d  <= 2'(req_burst >> (int'(win) * 2));
                        TXN_ID_R_d <= {seq, win};
                        rd_trn_en  <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    beat_cnt <= '0;
                    wdog     <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (rd_rsp_en_d) begin
                        rsp_data  <= rdata_d;
                        rsp_resp  <= rresp_d;
                        rsp_valid <= onehot(gnt_idx);
                        beat_cnt  <= beat_cnt + 4'd1;
                        wdog      <= '0;
                        if (rid_d != TXN_ID_R_d)
                            id_err <= 1'b1;
                        if (beat_cnt == arlen_d) begin
                            rsp_last <= 1'b1;
                            state    <= DONE;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        // Stalled: close the transaction with SLVERR.
                        rsp_data  <= '0;
                        rsp_resp  <= 2'b10;
                        rsp_valid <= onehot(gnt_idx);
                        rsp_last  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                DONE: begin
                    last_gnt   <= gnt_idx;
                    seq        <= seq + 2'd1;
                    araddr_d   <= '0;
                    TXN_ID_R_d <= '0;
                    arburst_d  <= '0;
                    arlen_d    <= '0;
                    arsize_d   <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_req_scheduler.sv
// Directed bench for axi_rd_req_scheduler with a cycle-stamped
// transaction model and per-cycle output comparison.
module tb_axi_rd_req_scheduler;
    localparam int TO = 16;

    logic        AClk = 1'b0;
    logic        ARst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [127:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic [11:0] req_size = '0;
    logic [7:0]  req_burst = '0;
    logic [31:0] araddr_d;
    logic [3:0]  TXN_ID_R_d;
    logic [1:0]  arburst_d;
    logic [3:0]  arlen_d;
    logic [2:0]  arsize_d;
    logic [1:0]  arlock_d;
    logic [1:0]  arcache_d;
    logic [2:0]  arprot_d;
    logic        rd_trn_en;
    logic [63:0] rdata_d = '0;
    logic [1:0]  rresp_d = '0;
    logic [3:0]  rid_d = '0;
    logic        rd_rsp_en_d = 1'b0;
    logic        r_last_d = 1'b0;
    logic [3:0]  rsp_valid;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        rsp_last;
    logic        id_err;
    logic        busy;

    axi_rd_req_scheduler #(
        .NUM_REQ(4), .addr_width(32), .data_width(64), .TIMEOUT(TO)
    ) dut (
        .AClk(AClk), .ARst(ARst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .req_size(req_size), .req_burst(req_burst),
        .araddr_d(araddr_d), .TXN_ID_R_d(TXN_ID_R_d),
        .arburst_d(arburst_d), .arlen_d(arlen_d), .arsize_d(arsize_d),
        .arlock_d(arlock_d), .arcache_d(arcache_d), .arprot_d(arprot_d),
        .rd_trn_en(rd_trn_en),
        .rdata_d(rdata_d), .rresp_d(rresp_d), .rid_d(rid_d),
        .rd_rsp_en_d(rd_rsp_en_d), .r_last_d(r_last_d),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .rsp_last(rsp_last), .id_err(id_err), .busy(busy)
    );

    always #5 AClk = ~AClk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int arb(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (v[2'(i)]) return i;
        end
        return -1;
    endfunction

    // Transaction model: grant cycle, issue on the next, beats or a
    // watchdog abort decide the final response cycle t_f.
    int cyc = 0;
    bit act = 0;
    bit fin = 0;
    int t_g, t_f, ref_c, nb, gidx;
    int m_last = 3;
    int m_seq = 0;
    bit err_m = 0;
    logic [31:0] h_addr;
    logic [3:0]  h_len, h_id;
    logic [2:0]  h_size;
    logic [1:0]  h_burst;
    bit          pend = 0;
    int          pend_cyc, pend_idx;
    logic [63:0] pend_data;
    logic [1:0]  pend_resp;
    bit          pend_last;
    int          glog[$];
    int          idlog[$];
    int          rsp_cnt = 0, last_cnt = 0, abort_cnt = 0;
    int          rdy_cnt[4] = '{0, 0, 0, 0};

    always @(negedge AClk) begin
        int w;
        bit ev;
        logic [3:0] exp_rdy;
        if (!ARst) begin
            chk("reset_ctl", 64'({req_ready, rd_trn_en, busy, rsp_valid, rsp_last,
                id_err, rsp_resp, TXN_ID_R_d, arlen_d, arsize_d, arburst_d,
                arlock_d, arcache_d, arprot_d}), 64'h0);
            chk("reset_addr_data", 64'(araddr_d) | rsp_data, 64'h0);
            act = 0; fin = 0; pend = 0; err_m = 0; m_last = 3; m_seq = 0;
        end else begin
            exp_rdy = '0;
            w = -1;
            if (!act) begin
                w = arb(req_valid, m_last);
                if (w >= 0) exp_rdy = 4'b0001 << w;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("rd_trn_en", 64'(rd_trn_en), 64'(act && cyc == t_g + 1));
            chk("busy", 64'(busy), 64'(act));
            chk("decoder", 64'({araddr_d, TXN_ID_R_d, arlen_d, arsize_d, arburst_d,
                arlock_d, arcache_d, arprot_d}),
                act ? 64'({h_addr, h_id, h_len, h_size, h_burst, 7'h0}) : 64'h0);
            ev = pend && pend_cyc == cyc;
            chk("rsp_valid", 64'(rsp_valid), ev ? 64'(4'b0001 << pend_idx) : 64'h0);
            chk("rsp_last", 64'(rsp_last), 64'(ev && pend_last));
            if (ev) begin
                chk("rsp_data", rsp_data, pend_data);
                chk("rsp_resp", 64'(rsp_resp), 64'(pend_resp));
                pend = 0;
            end
            chk("id_err", 64'(id_err), 64'(err_m));
            if (rsp_valid != 0) rsp_cnt++;
            if (rsp_valid != 0 && rsp_last) last_cnt++;
            if (rsp_valid != 0 && rsp_resp == 2'b10) abort_cnt++;
            for (int i = 0; i < 4; i++) if (req_ready[i]) rdy_cnt[i]++;

            if (!act) begin
                if (w >= 0) begin
                    act = 1; fin = 0; t_g = cyc; ref_c = cyc + 1; nb = 0; gidx = w;
                    h_addr  = req_addr[w*32 +: 32];
                    h_len   = req_len[w*4 +: 4];
                    h_size  = req_size[w*3 +: 3];
                    h_burst = req_burst[w*2 +: 2];
                    h_id    = 4'(m_seq * 4 + w);
                    glog.push_back(w);
                    idlog.push_back(int'(h_id));
                end
            end else if (!fin && cyc >= t_g + 2) begin
                if (rd_rsp_en_d) begin
                    pend = 1; pend_cyc = cyc + 1; pend_idx = gidx;
                    pend_data = rdata_d; pend_resp = rresp_d;
                    pend_last = (nb == int'(h_len));
                    if (rid_d != h_id) err_m = 1;
                    nb++;
                    ref_c = cyc;
                    if (pend_last) begin fin = 1; t_f = cyc + 1; end
                end else if (cyc - ref_c == TO - 1) begin
                    pend = 1; pend_cyc = cyc + 1; pend_idx = gidx;
                    pend_data = '0; pend_resp = 2'b10; pend_last = 1;
                    fin = 1; t_f = cyc + 1;
                end
            end else if (fin && cyc == t_f) begin
                act = 0;
                m_last = gidx;
                m_seq = (m_seq + 1) % 4;
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge AClk);
        #1;
    endtask

    task automatic do_reset();
        ARst = 1'b0;
        step(2);
        ARst = 1'b1;
        step(1);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] l);
        req_addr[i*32 +: 32] = a;
        req_len[i*4 +: 4]    = l;
        req_size[i*3 +: 3]   = 3'd3;
        req_burst[i*2 +: 2]  = 2'b01;
    endtask

    task automatic wait_trn();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rd_trn_en) ok = 1;
            else step(1);
        end
        chk("trn_timeout", 64'(ok), 64'h1);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            rd_rsp_en_d = 1'b1;
            rdata_d     = {$urandom, $urandom};
            rresp_d     = 2'b00;
            rid_d       = TXN_ID_R_d;
        end
        step(1);
        rd_rsp_en_d = 1'b0;
    endtask

    initial begin
        int b0, r0, l0;
        int rd0[4];
        for (int i = 0; i < 4; i++) set_req(i, 32'h2000 + 32'(i) * 32'h100, 4'd0);
        step(2);
        chk("init_busy", 64'(busy), 64'h0);
        chk("init_rsp", 64'(rsp_valid), 64'h0);
        ARst = 1'b1;
        step(1);

        // single requester, 4-beat burst
        set_req(0, 32'h1000, 4'd3);
        r0 = rsp_cnt; l0 = last_cnt;
        req_valid = 4'b0001;
        wait_trn();
        req_valid = 4'b0000;
        chk("t1_araddr", 64'(araddr_d), 64'h1000);
        chk("t1_arlen", 64'(arlen_d), 64'h3);
        chk("t1_txn_id", 64'(TXN_ID_R_d), 64'h0);
        beats(4);
        step(3);
        chk("t1_rsp_count", 64'(rsp_cnt - r0), 64'd4);
        chk("t1_last_count", 64'(last_cnt - l0), 64'd1);
        chk("t1_busy_after", 64'(busy), 64'h0);

        // all four requesting, round robin
        do_reset();
        set_req(0, 32'h2000, 4'd0);
        b0 = glog.size();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_trn();
            if (k == 4) req_valid = 4'b0000;
            beats(1);
        end
        step(3);
        begin
            int eg[5] = '{0, 1, 2, 3, 0};
            int ei[5] = '{0, 5, 10, 15, 0};
            chk("t2_grants", 64'(glog.size() - b0), 64'd5);
            for (int k = 0; k < 5 && b0 + k < glog.size(); k++) begin
                chk("t2_grant_order", 64'(glog[b0+k]), 64'(eg[k]));
                chk("t2_txn_id", 64'(idlog[b0+k]), 64'(ei[k]));
            end
        end

        // alternating 1,3
        do_reset();
        b0 = glog.size();
        for (int i = 0; i < 4; i++) rd0[i] = rdy_cnt[i];
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            wait_trn();
            if (k == 3) req_valid = 4'b0000;
            beats(1);
        end
        step(3);
        begin
            int eg[4] = '{1, 3, 1, 3};
            chk("t3_grants", 64'(glog.size() - b0), 64'd4);
            for (int k = 0; k < 4 && b0 + k < glog.size(); k++)
                chk("t3_grant_order", 64'(glog[b0+k]), 64'(eg[k]));
        end
        chk("t3_ready0", 64'(rdy_cnt[0] - rd0[0]), 64'd0);
        chk("t3_ready2", 64'(rdy_cnt[2] - rd0[2]), 64'd0);

        // watchdog abort after one of two beats
        do_reset();
        set_req(0, 32'h3000, 4'd1);
        r0 = abort_cnt;
        req_valid = 4'b0001;
        wait_trn();
        req_valid = 4'b0000;
        beats(1);
        step(14);
        chk("t4_no_early_abort", 64'(rsp_valid), 64'h0);
        step(1);
        chk("t4_abort_valid", 64'(rsp_valid), 64'h1);
        chk("t4_abort_resp", 64'(rsp_resp), 64'h2);
        chk("t4_abort_last", 64'(rsp_last), 64'h1);
        chk("t4_abort_data", rsp_data, 64'h0);
        step(3);
        chk("t4_idle", 64'(busy), 64'h0);
        r0 = rsp_cnt;
        rd_rsp_en_d = 1'b1;
        step(1);
        rd_rsp_en_d = 1'b0;
        step(2);
        chk("t4_late_beat_dropped", 64'(rsp_cnt - r0), 64'd0);

        // rid mismatch is forwarded and flagged stickily
        do_reset();
        set_req(1, 32'h4000, 4'd0);
        req_valid = 4'b0010;
        wait_trn();
        req_valid = 4'b0000;
        chk("t5_txn_id", 64'(TXN_ID_R_d), 64'h1);
        step(1);
        rd_rsp_en_d = 1'b1;
        rdata_d = 64'hDEAD_BEEF_0123_4567;
        rid_d = 4'h7;
        step(1);
        rd_rsp_en_d = 1'b0;
        chk("t5_data_fwd", rsp_data, 64'hDEAD_BEEF_0123_4567);
        chk("t5_valid_fwd", 64'(rsp_valid), 64'h2);
        chk("t5_id_err", 64'(id_err), 64'h1);
        step(2);
        req_valid = 4'b0010;
        wait_trn();
        req_valid = 4'b0000;
        beats(1);
        step(3);
        chk("t5_id_err_sticky", 64'(id_err), 64'h1);

        // reset in the middle of a burst
        do_reset();
        set_req(0, 32'h5000, 4'd3);
        set_req(2, 32'h6000, 4'd0);
        req_valid = 4'b0001;
        wait_trn();
        req_valid = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step(1);
            rd_rsp_en_d = 1'b1;
            rdata_d = 64'(i + 1);
            rid_d = TXN_ID_R_d;
        end
        step(1);
        rd_rsp_en_d = 1'b0;
        ARst = 1'b0;
        #1;
        chk("t6_async_zero", 64'({busy, rsp_valid, rsp_last, rd_trn_en, TXN_ID_R_d,
            arlen_d, id_err}), 64'h0);
        chk("t6_async_addr", 64'(araddr_d) | rsp_data, 64'h0);
        step(2);
        ARst = 1'b1;
        req_valid = 4'b0100;
        wait_trn();
        req_valid = 4'b0000;
        chk("t6_txn_id", 64'(TXN_ID_R_d), 64'h2);
        chk("t6_araddr", 64'(araddr_d), 64'h6000);
        beats(1);
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_rd_req_scheduler.md
Name: axi_rd_req_scheduler

Overview:
- Shares the single AXI master read-channel controller among NUM_REQ independent read requesters.
- Round-robin arbitration picks one requester at a time. The block latches that requester's address/control, presents it on the controller's decoder-side inputs, and pulses rd_trn_en once.
- Returned beats (rd_rsp_en_d) are counted and routed back to the granted requester.
- Only one transaction is in flight at a time. A watchdog aborts a stalled transaction with SLVERR.

Parameters:
- NUM_REQ, 4, number of requesters (2..4).
- addr_width, 32, address width.
- data_width, 64, read data width.
- TIMEOUT, 256, maximum cycles allowed between issue/last beat and the next beat before abort (>=4).

Ports:
- AClk  in  1  clock.
- ARst  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a pending read.
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- req_addr  in  NUM_REQ*addr_width  packed start addresses; slice i belongs to requester i.
- req_len  in  NUM_REQ*4  packed burst length minus 1.
- req_size  in  NUM_REQ*3  packed beat size.
- req_burst  in  NUM_REQ*2  packed burst type.
- araddr_d  out  addr_width  to controller.
- TXN_ID_R_d  out  4  to controller; {seq[1:0], gnt_idx[1:0]}.
- arburst_d  out  2  to controller.
- arlen_d  out  4  to controller.
- arsize_d  out  3  to controller.
- arlock_d  out  2  to controller; constant 2'b00.
- arcache_d  out  2  to controller; constant 2'b00.
- arprot_d  out  3  to controller; constant 3'b000.
- rd_trn_en  out  1  transaction start pulse.
- rdata_d  in  data_width  beat data from controller.
- rresp_d  in  2  beat response.
- rid_d  in  4  beat ID.
- rd_rsp_en_d  in  1  beat valid.
- r_last_d  in  1  controller last indication; informational only.
- rsp_valid  out  NUM_REQ  one-hot beat valid to the granted requester.
- rsp_data  out  data_width  shared beat data.
- rsp_resp  out  2  beat response.
- rsp_last  out  1  final beat of the transaction.
- id_err  out  1  sticky flag: rid_d mismatch seen.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (ARst low, asynchronous): all outputs are 0, state=IDLE, seq=0, last_gnt=NUM_REQ-1 (requester 0 has first priority), beat/watchdog counters are 0. Asserting reset mid-transaction aborts it silently; no rsp_valid is produced.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching from last_gnt+1 with wrap modulo NUM_REQ.
  - At the clock edge: pulse req_ready[winner] for one cycle, latch the winner's addr/len/size/burst into holding registers, set gnt_idx=winner, then go to ISSUE.
  - If no req_valid is high, stay in IDLE.
- ISSUE:
  - rd_trn_en=1 for exactly this one cycle.
  - Decoder-side outputs are driven from the holding registers from ISSUE through DONE and stay stable the whole time.
  - Load beat_cnt=0 and wdog=0. Go to WAIT.
- WAIT: on each rd_rsp_en_d=1:
  - Register rsp_data=rdata_d and rsp_resp=rresp_d, and pulse rsp_valid[gnt_idx] the next cycle (1-cycle latency).
  - Increment beat_cnt and clear wdog.
  - If rid_d != TXN_ID_R_d, set id_err (it stays set until reset); the beat is still forwarded.
  - When beat_cnt reaches len (the (len+1)th beat), assert rsp_last with that beat and go to DONE.
- Completion is decided by beat count only. r_last_d is ignored for completion.
- Watchdog: wdog increments every WAIT cycle without a beat. When wdog reaches TIMEOUT-1, emit one rsp_valid[gnt_idx] with rsp_resp=2'b10, rsp_data=0, rsp_last=1, then go to DONE. Any beats arriving after the abort are dropped.
- A beat and a watchdog expiry in the same cycle: the beat wins and the watchdog clears.
- DONE (one cycle): last_gnt=gnt_idx, seq=seq+1 (2-bit, wraps 3->0). Go to IDLE. The earliest next req_ready is the cycle after DONE.
- Decoder-side outputs return to 0 in IDLE.
- req_valid on the granted requester after its req_ready is treated as a new request.
- Bit slices of req_* beyond NUM_REQ are ignored.

Test Plan:
- Only req_valid[0]; len=3, addr=0x1000, INCR; 4 beats returned:
  - req_ready[0] pulses, rd_trn_en pulses the next cycle, araddr_d=0x1000, arlen_d=3, TXN_ID_R_d=4'h0.
  - 4 rsp_valid[0] pulses are produced, with rsp_last on the 4th; busy is low after DONE.
- req_valid=4'b1111 held, each request len=0:
  - Grant order is 0,1,2,3,0.
  - TXN_ID_R_d sequence is 0x0, 0x5, 0xA, 0xF, 0x0.
- req_valid=4'b1010 held: grants alternate 1,3,1,3; requesters 0 and 2 never receive req_ready.
- TIMEOUT=16, len=1, only 1 beat returned, then silence:
  - After 15 idle WAIT cycles, one rsp_valid is produced with rsp_resp=2'b10 and rsp_last=1.
  - The FSM returns to IDLE; a late beat produces no rsp_valid.
- Beat with rid_d=4'h7 when TXN_ID_R_d=4'h1: the data is still forwarded, id_err=1 and stays set across following transactions.
- ARst low during WAIT after 2 of 4 beats: all outputs are 0 immediately. After release, req_valid[2] alone is granted with TXN_ID_R_d=4'h2 (seq has restarted at 0).
